axi_master_rd_if: RTL and testbench

AXI read-side initiator, the opposite end of the team's AXI slave interface. It accepts one linear read command (start address, beat count) from a local client and splits it into INCR bursts on the AR channel. Splits occur at MAX_BURST beats and at 4 KB boundaries. R beats stream back to the client with backpressure, and a single completion pulse reports aggregate error status.

---
 rtl/axi_master_rd_if.sv | 197 +++++++++++++++++++
 tb/tb_axi_master_rd_if.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rd_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_rd_if
// Purpose  : AXI read initiator. Takes one linear read command (address,
//            beat count), issues INCR bursts split at MAX_BURST beats and at
//            4 KB boundaries, streams R beats to the client with backpressure
//            and reports a single sticky error with a completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axi_master_rd_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 16,
  parameter int MAX_BURST      = 16
) (
  input  logic                      axi_clk_in,
  input  logic                      axi_rstn_in,
  // client command
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [15:0]               cmd_beats_in,
  // client read data
  output logic [AXI_DATA_WIDTH-1:0] rd_data_out,
  output logic                      rd_valid_out,
  input  logic                      rd_ready_in,
  output logic                      done_valid_out,
  output logic                      done_err_out,
  // AXI AR channel
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr_out,
  output logic [1:0]                axi_arburst_out,
  output logic [AXI_ID_WIDTH-1:0]   axi_arid_out,
  output logic [7:0]                axi_arlen_out,
  output logic [2:0]                axi_arsize_out,
  output logic                      axi_arvalid_out,
  input  logic                      axi_arready_in,
  // AXI R channel
  input  logic [AXI_ID_WIDTH-1:0]   axi_rid_in,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata_in,
  input  logic [1:0]                axi_rresp_in,
  input  logic                      axi_rlast_in,
  input  logic                      axi_rvalid_in,
  output logic                      axi_rready_out
);

  localparam int BPB      = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BPB);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);

  // one-hot states
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_AR   = 4'b0010;
  localparam logic [3:0] S_R    = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  logic [3:0]                state;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [15:0]               remaining;
  logic [8:0]                beat_cnt;
  logic                      err;
  logic                      arvalid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic                      done_valid;
  logic                      done_err;

  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_aligned;
  logic [AXI_ADDR_WIDTH-1:0] len_addr;
  logic [15:0]               len_rem;
  logic [12:0]               bytes_to_4k;
  logic [12:0]               beats_to_4k;
  logic [16:0]               len_n;
  logic [8:0]                burst_beats;
  logic [AXI_ADDR_WIDTH-1:0] burst_bytes;
  logic                      in_r;
  logic                      beat_xfer;
  logic                      last_beat;
  logic                      beat_err;

  assign cmd_addr_aligned = cmd_addr_in & ADDR_MASK;

  // The next burst is sized either from the incoming command (leaving IDLE)
  // or from the already-advanced running address/count (leaving R).
  assign len_addr = (state == S_IDLE) ? cmd_addr_aligned : cur_addr;
  assign len_rem  = (state == S_IDLE) ? cmd_beats_in     : remaining;

  // Burst length = min(remaining, MAX_BURST, beats left before the 4 KB line)
  always_comb begin
    bytes_to_4k = 13'd4096 - {1'b0, len_addr[11:0]};
    beats_to_4k = bytes_to_4k >> ADDR_LSB;
    len_n       = {1'b0, len_rem};
    if (len_n > 17'(MAX_BURST)) begin
      len_n = 17'(MAX_BURST);
    end
    if (len_n > {4'd0, beats_to_4k}) begin
      len_n = {4'd0, beats_to_4k};
    end
  end

  assign burst_beats = {1'b0, arlen} + 9'd1;
  assign burst_bytes = AXI_ADDR_WIDTH'(burst_beats) << ADDR_LSB;

  assign in_r      = (state == S_R);
  assign beat_xfer = in_r & axi_rvalid_in & rd_ready_in;
  assign last_beat = (beat_cnt == 9'd1);
  // Any bad response code, foreign ID or misplaced RLAST poisons the command.
  assign beat_err  = axi_rresp_in[1] | (axi_rid_in != '0) | (axi_rlast_in != last_beat);

  assign cmd_ready_out   = (state == S_IDLE);
  assign rd_valid_out    = in_r & axi_rvalid_in;
  assign axi_rready_out  = in_r & rd_ready_in;
  assign rd_data_out     = axi_rdata_in;
  assign done_valid_out  = done_valid;
  assign done_err_out    = done_err;
  assign axi_araddr_out  = araddr;
  assign axi_arlen_out   = arlen;
  assign axi_arvalid_out = arvalid;
  assign axi_arburst_out = 2'd1;
  assign axi_arid_out    = '0;
  assign axi_arsize_out  = 3'(ADDR_LSB);

  // Command sequencing: burst issue, beat counting, error accumulation, done
  always_ff @(posedge axi_clk_in) begin
    if (!axi_rstn_in) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_in) begin
            cur_addr  <= cmd_addr_aligned;
            remaining <= cmd_beats_in;
            err       <= 1'b0;
            if (cmd_beats_in == 16'd0) begin
              state      <= S_DONE;
              done_valid <= 1'b1;
            end else begin
              state   <= S_AR;
              arvalid <= 1'b1;
              araddr  <= cmd_addr_aligned;
              arlen   <= 8'(len_n - 17'd1);
            end
          end
        end
        S_AR: begin
          // arvalid is high for the whole AR stay, so arready alone completes it
          if (axi_arready_in) begin
            arvalid   <= 1'b0;
            beat_cnt  <= burst_beats;
            cur_addr  <= cur_addr + burst_bytes;
            remaining <= remaining - 16'(burst_beats);
            state     <= S_R;
          end
        end
        S_R: begin
          if (beat_xfer) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_err) begin
              err <= 1'b1;
            end
            // The burst ends on the counted final beat, whatever rlast says.
            if (last_beat) begin
              if (remaining != 16'd0) begin
                state   <= S_AR;
                arvalid <= 1'b1;
                araddr  <= cur_addr;
                arlen   <= 8'(len_n - 17'd1);
              end else begin
                state      <= S_DONE;
                done_valid <= 1'b1;
                done_err   <= err | beat_err;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_master_rd_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_master_rd_if
// Purpose  : Directed self-checking bench for axi_master_rd_if with a small
//            AXI read slave and client model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_master_rd_if;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        done_valid;
  logic        done_err;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [15:0] arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [15:0] rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  axi_master_rd_if dut (
    .axi_clk_in      (clk),
    .axi_rstn_in     (rstn),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_addr_in     (cmd_addr),
    .cmd_beats_in    (cmd_beats),
    .rd_data_out     (rd_data),
    .rd_valid_out    (rd_valid),
    .rd_ready_in     (rd_ready),
    .done_valid_out  (done_valid),
    .done_err_out    (done_err),
    .axi_araddr_out  (araddr),
    .axi_arburst_out (arburst),
    .axi_arid_out    (arid),
    .axi_arlen_out   (arlen),
    .axi_arsize_out  (arsize),
    .axi_arvalid_out (arvalid),
    .axi_arready_in  (arready),
    .axi_rid_in      (rid),
    .axi_rdata_in    (rdata),
    .axi_rresp_in    (rresp),
    .axi_rlast_in    (rlast),
    .axi_rvalid_in   (rvalid),
    .axi_rready_out  (rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t      bq[$];
  burst_t      ar_log[$];
  logic [31:0] rx[$];
  int stall_left = 0, ar_wait = 0, rd_mode = 0, resp_err_idx = -1, early_last_idx = -1;
  int cyc = 0, accept_cyc = 0, first_ar_cyc = -1, done_cnt = 0, done_cyc = 0;
  int mirror_bad = 0, hold_bad = 0;
  logic   done_err_seen = 1'b0;
  logic   active = 1'b0, beat_taken = 1'b0, prev_wait = 1'b0;
  burst_t cur;
  int     idx = 0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  // Slave + client model: drive at negedge, observe handshakes 1 unit later
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (beat_taken) begin
          beat_taken = 1'b0;
          idx++;
          if (idx > int'(cur.len)) active = 1'b0;
        end
        if (!active && bq.size() > 0) begin
          cur = bq.pop_front();
          idx = 0;
          active = 1'b1;
        end
        if (active) begin
          rvalid = 1'b1;
          rdata  = 32'hD000_0000 | (cur.addr + 32'(idx * 4));
          rresp  = (idx == resp_err_idx) ? 2'd2 : 2'd0;
          rlast  = (idx == int'(cur.len)) || (idx == early_last_idx);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          rresp  = 2'd0;
        end
        if (arvalid) begin
          if (stall_left > 0) begin
            arready = 1'b0;
            stall_left--;
          end else begin
            arready = 1'b1;
          end
        end else begin
          arready = 1'b0;
        end
        rd_ready = (rd_mode == 1) ? ~rd_ready : 1'b1;
      end
      #1;
      if (!rstn) begin
        bq.delete();
        active = 1'b0;
        beat_taken = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) accept_cyc = cyc;
        if (arvalid) begin
          if (first_ar_cyc < 0) first_ar_cyc = cyc;
          if (prev_wait && (araddr !== prev_addr || arlen !== prev_len)) hold_bad++;
          if (arready) begin
            ar_log.push_back(burst_t'({araddr, arlen}));
            bq.push_back(burst_t'({araddr, arlen}));
            prev_wait = 1'b0;
          end else begin
            ar_wait++;
            prev_wait = 1'b1;
            prev_addr = araddr;
            prev_len  = arlen;
          end
        end else begin
          if (prev_wait) hold_bad++;
          prev_wait = 1'b0;
        end
        if (active) begin
          if (rready !== rd_ready) mirror_bad++;
          if (rd_valid !== 1'b1) mirror_bad++;
          if (rready === 1'b1) begin
            rx.push_back(rd_data);
            beat_taken = 1'b1;
          end
        end
        if (done_valid) begin
          done_cnt++;
          done_cyc = cyc;
          done_err_seen = done_err;
        end
      end
    end
  end

  task automatic clear_logs();
    ar_log.delete();
    rx.delete();
    done_cnt = 0;
    first_ar_cyc = -1;
    ar_wait = 0;
    hold_bad = 0;
    mirror_bad = 0;
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [15:0] n);
    int t;
    clear_logs();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = n;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_ar(input string tag, input int i, input logic [31:0] a, input logic [7:0] l);
    if (ar_log.size() > i) begin
      check({tag, "_araddr"}, 64'(ar_log[i].addr), 64'(a));
      check({tag, "_arlen"}, 64'(ar_log[i].len), 64'(l));
    end else begin
      check({tag, "_missing"}, 64'(ar_log.size()), 64'(i + 1));
    end
  endtask

  task automatic check_rx(input string tag, input logic [31:0] a, input int n);
    check({tag, "_beats"}, 64'(rx.size()), 64'(n));
    for (int k = 0; k < n && k < rx.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), 64'(rx[k]), 64'(32'hD000_0000 | (a + 32'(4 * k))));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_done", 64'({done_valid, done_err}), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 8-beat burst
    run_cmd(32'h1000, 16'd8);
    check("t1_ar_count", 64'(ar_log.size()), 64'd1);
    check_ar("t1_ar0", 0, 32'h1000, 8'd7);
    check("t1_arsize", 64'(arsize), 64'd2);
    check("t1_arburst", 64'(arburst), 64'd1);
    check("t1_arid", 64'(arid), 64'd0);
    check("t1_ar_latency", 64'(first_ar_cyc - accept_cyc), 64'd1);
    check_rx("t1", 32'h1000, 8);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_done_err", 64'(done_err_seen), 64'd0);

    // 2: 4 KB split
    run_cmd(32'h0FF8, 16'd6);
    check("t2_ar_count", 64'(ar_log.size()), 64'd2);
    check_ar("t2_ar0", 0, 32'h0FF8, 8'd1);
    check_ar("t2_ar1", 1, 32'h1000, 8'd3);
    check_rx("t2", 32'h0FF8, 6);
    check("t2_done_err", 64'(done_err_seen), 64'd0);

    // 3: MAX_BURST split with arready stalled 5 cycles
    stall_left = 5;
    run_cmd(32'h0, 16'd40);
    check("t3_ar_count", 64'(ar_log.size()), 64'd3);
    check_ar("t3_ar0", 0, 32'h00, 8'd15);
    check_ar("t3_ar1", 1, 32'h40, 8'd15);
    check_ar("t3_ar2", 2, 32'h80, 8'd7);
    check("t3_ar_wait", 64'(ar_wait), 64'd5);
    check("t3_ar_hold", 64'(hold_bad), 64'd0);
    check_rx("t3", 32'h0, 40);
    check("t3_done_err", 64'(done_err_seen), 64'd0);

    // 4: client backpressure toggling every cycle
    rd_mode = 1;
    run_cmd(32'h2000, 16'd4);
    rd_mode = 0;
    check("t4_rready_mirror", 64'(mirror_bad), 64'd0);
    check_rx("t4", 32'h2000, 4);
    check("t4_done_err", 64'(done_err_seen), 64'd0);

    // 5a: SLVERR on third beat
    resp_err_idx = 2;
    run_cmd(32'h3000, 16'd4);
    resp_err_idx = -1;
    check_rx("t5a", 32'h3000, 4);
    check("t5a_done_cnt", 64'(done_cnt), 64'd1);
    check("t5a_done_err", 64'(done_err_seen), 64'd1);

    // 5b: early rlast on second beat
    early_last_idx = 1;
    run_cmd(32'h3100, 16'd4);
    early_last_idx = -1;
    check_rx("t5b", 32'h3100, 4);
    check("t5b_done_err", 64'(done_err_seen), 64'd1);

    // 6a: zero-beat command
    run_cmd(32'h4000, 16'd0);
    check("t6a_ar_count", 64'(ar_log.size()), 64'd0);
    check("t6a_done_cnt", 64'(done_cnt), 64'd1);
    check("t6a_done_latency", 64'(done_cyc - accept_cyc), 64'd1);
    check("t6a_done_err", 64'(done_err_seen), 64'd0);

    // 6b: reset in the middle of the R phase
    clear_logs();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h5000;
    cmd_beats = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int t = 0; t < 200 && rx.size() < 3; t++) begin
      @(negedge clk);
      #2;
    end
    check("t6b_reached_r", 64'(rx.size() >= 3), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #2;
    check("t6b_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6b_rd_valid", 64'(rd_valid), 64'd0);
    check("t6b_rready", 64'(rready), 64'd0);
    check("t6b_arvalid", 64'(arvalid), 64'd0);
    check("t6b_araddr", 64'(araddr), 64'd0);
    check("t6b_done", 64'(done_valid), 64'd0);
    clear_logs();
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("t6b_no_done", 64'(done_cnt), 64'd0);
    check("t6b_no_ar", 64'(ar_log.size()), 64'd0);

    // recovery after reset
    run_cmd(32'h6000, 16'd2);
    check_rx("t6c", 32'h6000, 2);
    check("t6c_done_cnt", 64'(done_cnt), 64'd1);
    check("t6c_done_err", 64'(done_err_seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
